charmap_console: RTL and testbench



---
 rtl/charmap_pkg.sv | 26 ++
 rtl/charmap_cell_counter.sv | 64 ++++++
 rtl/charmap_console.sv | 241 ++++++++++++++++++++++++
 tb/tb_charmap_console.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/charmap_pkg.sv
// Shared definitions for the character-map console writer: FSM states,
// control codes, default geometry and the RAM address packing helper.
package charmap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_SCROLL_FILL
    } state_t;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam int DEF_COLS = 40;
    localparam int DEF_ROWS = 30;

    // RAM address is row-major with a fixed 64-cell row pitch: {y, x}.
    function automatic logic [11:0] pack_addr(input logic [5:0] y, input logic [5:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/charmap_cell_counter.sv
// Cell walker shared by the clear, scroll-copy and scroll-fill sequences.
// Walks x inner / y outer across COLS columns; last_o flags the final
// column of the row selected by last_row_i.
module charmap_cell_counter
    import charmap_pkg::*;
#(
    parameter int COLS = DEF_COLS
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [5:0] load_y_i,
    input  logic       step_i,
    input  logic [5:0] last_row_i,
    output logic [5:0] x_o,
    output logic [5:0] y_o,
    output logic [5:0] next_x_o,
    output logic [5:0] next_y_o,
    output logic       last_o
);

    localparam logic [5:0] X_MAX = 6'(COLS - 1);

    logic [5:0] x_q, y_q;
    logic [5:0] x_d, y_d;
    logic [5:0] step_x, step_y;

    // Next position: load restarts at column 0 of the requested row.
    always_comb begin
        step_x = x_q + 6'd1;
        step_y = y_q;
        if (x_q == X_MAX) begin
            step_x = '0;
            step_y = y_q + 6'd1;
        end
        x_d = x_q;
        y_d = y_q;
        if (load_i) begin
            x_d = '0;
            y_d = load_y_i;
        end else if (step_i) begin
            x_d = step_x;
            y_d = step_y;
        end
    end

    // Position register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o      = x_q;
    assign y_o      = y_q;
    assign next_x_o = step_x;
    assign next_y_o = step_y;
    assign last_o   = (x_q == X_MAX) && (y_q == last_row_i);

endmodule

// File: rtl/charmap_console.sv
// Character-stream writer for the character/colour RAMs.
// Optional feature macro: CHARMAP_CONSOLE_SCROLL_EN enables the one-row
// scroll-up; without it the cursor wraps from the bottom row to the top.
// During a scroll copy the write data is taken straight from the RAM read
// port (selected by a registered flag) so each cell needs only two cycles.
module charmap_console
    import charmap_pkg::*;
#(
    parameter int         COLS     = DEF_COLS,
    parameter int         ROWS     = DEF_ROWS,
    parameter logic [7:0] CLEAR_FG = 8'hFF,
    parameter logic [7:0] CLEAR_BG = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_char,
    input  logic [7:0]  in_fg,
    input  logic [7:0]  in_bg,
    input  logic        clear,
    output logic [11:0] chram_addr,
    output logic        chram_wr,
    output logic [7:0]  chmap_data_in,
    output logic [7:0]  fgcolram_data_in,
    output logic [7:0]  bgcolram_data_in,
    input  logic [7:0]  chmap_data_out,
    input  logic [7:0]  fgcolram_data_out,
    input  logic [7:0]  bgcolram_data_out,
    output logic [5:0]  cursor_x,
    output logic [5:0]  cursor_y,
    output logic        busy
);

    localparam logic [5:0] X_MAX = 6'(COLS - 1);
    localparam logic [5:0] Y_MAX = 6'(ROWS - 1);
`ifdef CHARMAP_CONSOLE_SCROLL_EN
    localparam bit         HAS_COPY      = (ROWS > 1);
    localparam logic [5:0] COPY_LAST_ROW = (ROWS > 1) ? 6'(ROWS - 2) : 6'd0;
`endif

    state_t      state_q;
    logic [5:0]  cur_x_q, cur_y_q;
    logic [7:0]  fill_fg_q, fill_bg_q;
    logic [11:0] addr_q;
    logic        wr_q;
    logic [7:0]  ch_q, fg_q, bg_q;
    logic        busy_q;

    logic        accept, printable, adv_row, at_bottom;
    logic        cnt_load, cnt_step, cnt_last;
    logic [5:0]  cnt_load_y, cnt_last_row;
    logic [5:0]  cnt_x, cnt_y, cnt_nx, cnt_ny;

    assign in_ready  = (state_q == ST_IDLE) && !clear;
    assign accept    = in_valid && in_ready;
    assign printable = (in_char != CH_LF) && (in_char != CH_CR) && (in_char != CH_BS);
    assign adv_row   = accept && ((in_char == CH_LF) || (printable && (cur_x_q == X_MAX)));
    assign at_bottom = (cur_y_q == Y_MAX);

    charmap_cell_counter #(
        .COLS (COLS)
    ) u_walker (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (cnt_load),
        .load_y_i   (cnt_load_y),
        .step_i     (cnt_step),
        .last_row_i (cnt_last_row),
        .x_o        (cnt_x),
        .y_o        (cnt_y),
        .next_x_o   (cnt_nx),
        .next_y_o   (cnt_ny),
        .last_o     (cnt_last)
    );

    // Walker control: the walker always holds the cell the current state acts on.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_y   = '0;
        cnt_step     = 1'b0;
        cnt_last_row = Y_MAX;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    cnt_load = 1'b1;
                end
`ifdef CHARMAP_CONSOLE_SCROLL_EN
                else if (adv_row && at_bottom) begin
                    cnt_load   = 1'b1;
                    cnt_load_y = HAS_COPY ? 6'd0 : Y_MAX;
                end
`endif
            end
            ST_CLEAR: cnt_step = !cnt_last;
`ifdef CHARMAP_CONSOLE_SCROLL_EN
            ST_SCROLL_RD: cnt_last_row = COPY_LAST_ROW;
            ST_SCROLL_WR: begin
                cnt_last_row = COPY_LAST_ROW;
                if (cnt_last) begin
                    cnt_load   = 1'b1;
                    cnt_load_y = Y_MAX;
                end else begin
                    cnt_step = 1'b1;
                end
            end
            ST_SCROLL_FILL: cnt_step = !cnt_last;
`endif
            default: ;
        endcase
    end

`ifdef CHARMAP_CONSOLE_SCROLL_EN
    logic fwd_q;
`endif

    // Main FSM with registered cursor, fill colours and RAM-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            fill_fg_q <= CLEAR_FG;
            fill_bg_q <= CLEAR_BG;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            ch_q      <= '0;
            fg_q      <= '0;
            bg_q      <= '0;
            busy_q    <= 1'b0;
`ifdef CHARMAP_CONSOLE_SCROLL_EN
            fwd_q     <= 1'b0;
`endif
        end else begin
            wr_q <= 1'b0;
`ifdef CHARMAP_CONSOLE_SCROLL_EN
            fwd_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        // First clear write goes out the very next cycle.
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        wr_q    <= 1'b1;
                        addr_q  <= pack_addr(6'd0, 6'd0);
                        ch_q    <= CH_SPACE;
                        fg_q    <= CLEAR_FG;
                        bg_q    <= CLEAR_BG;
                        cur_x_q <= '0;
                        cur_y_q <= '0;
                    end else if (in_valid) begin
                        fill_fg_q <= in_fg;
                        fill_bg_q <= in_bg;
                        if (in_char == CH_LF || in_char == CH_CR) begin
                            cur_x_q <= '0;
                        end else if (in_char == CH_BS) begin
                            if (cur_x_q != 6'd0) begin
                                cur_x_q <= cur_x_q - 6'd1;
                            end
                        end else begin
                            wr_q    <= 1'b1;
                            addr_q  <= pack_addr(cur_y_q, cur_x_q);
                            ch_q    <= in_char;
                            fg_q    <= in_fg;
                            bg_q    <= in_bg;
                            cur_x_q <= (cur_x_q == X_MAX) ? 6'd0 : cur_x_q + 6'd1;
                        end
                        if (adv_row) begin
                            if (!at_bottom) begin
                                cur_y_q <= cur_y_q + 6'd1;
                            end else begin
`ifdef CHARMAP_CONSOLE_SCROLL_EN
                                state_q <= HAS_COPY ? ST_SCROLL_RD : ST_SCROLL_FILL;
                                busy_q  <= 1'b1;
`else
                                cur_y_q <= '0;
`endif
                            end
                        end
                    end
                end
                ST_CLEAR: begin
                    if (cnt_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        wr_q   <= 1'b1;
                        addr_q <= pack_addr(cnt_ny, cnt_nx);
                    end
                end
`ifdef CHARMAP_CONSOLE_SCROLL_EN
                ST_SCROLL_RD: begin
                    addr_q  <= pack_addr(cnt_y + 6'd1, cnt_x);
                    state_q <= ST_SCROLL_WR;
                end
                ST_SCROLL_WR: begin
                    wr_q    <= 1'b1;
                    fwd_q   <= 1'b1;
                    addr_q  <= pack_addr(cnt_y, cnt_x);
                    state_q <= cnt_last ? ST_SCROLL_FILL : ST_SCROLL_RD;
                end
                ST_SCROLL_FILL: begin
                    wr_q   <= 1'b1;
                    addr_q <= pack_addr(cnt_y, cnt_x);
                    ch_q   <= CH_SPACE;
                    fg_q   <= fill_fg_q;
                    bg_q   <= fill_bg_q;
                    if (cnt_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign chram_addr = addr_q;
    assign chram_wr   = wr_q;
    assign cursor_x   = cur_x_q;
    assign cursor_y   = cur_y_q;
    assign busy       = busy_q;

`ifdef CHARMAP_CONSOLE_SCROLL_EN
    assign chmap_data_in    = fwd_q ? chmap_data_out    : ch_q;
    assign fgcolram_data_in = fwd_q ? fgcolram_data_out : fg_q;
    assign bgcolram_data_in = fwd_q ? bgcolram_data_out : bg_q;
`else
    logic unused_rd;
    assign unused_rd        = ^{chmap_data_out, fgcolram_data_out, bgcolram_data_out};
    assign chmap_data_in    = ch_q;
    assign fgcolram_data_in = fg_q;
    assign bgcolram_data_in = bg_q;
`endif

endmodule

// File: tb/tb_charmap_console.sv
// Testbench for charmap_console with a behavioural RAM (1-cycle read latency).
module tb_charmap_console;
    import charmap_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_char = '0, in_fg = '0, in_bg = '0;
    logic        clear = 1'b0;
    logic [11:0] chram_addr;
    logic        chram_wr;
    logic [7:0]  chmap_data_in, fgcolram_data_in, bgcolram_data_in;
    logic [7:0]  rd_ch, rd_fg, rd_bg;
    logic [5:0]  cursor_x, cursor_y;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    charmap_console dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_char           (in_char),
        .in_fg             (in_fg),
        .in_bg             (in_bg),
        .clear             (clear),
        .chram_addr        (chram_addr),
        .chram_wr          (chram_wr),
        .chmap_data_in     (chmap_data_in),
        .fgcolram_data_in  (fgcolram_data_in),
        .bgcolram_data_in  (bgcolram_data_in),
        .chmap_data_out    (rd_ch),
        .fgcolram_data_out (rd_fg),
        .bgcolram_data_out (rd_bg),
        .cursor_x          (cursor_x),
        .cursor_y          (cursor_y),
        .busy              (busy)
    );

    // Behavioural RAMs: synchronous write, registered read.
    logic [7:0] mem_ch [4096];
    logic [7:0] mem_fg [4096];
    logic [7:0] mem_bg [4096];
    logic       ram_init = 1'b1;
    int         busy_total = 0;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) begin
                mem_ch[i] <= 8'hEE;
                mem_fg[i] <= 8'hEE;
                mem_bg[i] <= 8'hEE;
            end
        end else if (chram_wr) begin
            mem_ch[chram_addr] <= chmap_data_in;
            mem_fg[chram_addr] <= fgcolram_data_in;
            mem_bg[chram_addr] <= bgcolram_data_in;
        end
        rd_ch <= mem_ch[chram_addr];
        rd_fg <= mem_fg[chram_addr];
        rd_bg <= mem_bg[chram_addr];
        if (busy) busy_total <= busy_total + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] a(input int y, input int x);
        return {6'(y), 6'(x)};
    endfunction

    function automatic logic [7:0] code(input int y, input int x);
        return 8'(33 + ((y * 3 + x) % 90));
    endfunction

    task automatic send(input logic [7:0] c, input logic [7:0] f, input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1; in_char = c; in_fg = f; in_bg = b;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0; clear = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; clear = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_wr", chram_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cx", cursor_x, 0);
        chk("rst_cy", cursor_y, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  ch, fg, bg;
        logic        wr;
        logic [11:0] addr;
        logic [5:0]  x, y;
    } vec_t;

    vec_t vecs[11];

    task automatic apply(input int i);
        send(vecs[i].ch, vecs[i].fg, vecs[i].bg);
        chk($sformatf("v%0d_wr", i), chram_wr, vecs[i].wr);
        if (vecs[i].wr) begin
            chk($sformatf("v%0d_addr", i), chram_addr, vecs[i].addr);
            chk($sformatf("v%0d_ch", i), chmap_data_in, vecs[i].ch);
            chk($sformatf("v%0d_fg", i), fgcolram_data_in, vecs[i].fg);
            chk($sformatf("v%0d_bg", i), bgcolram_data_in, vecs[i].bg);
        end
        chk($sformatf("v%0d_cx", i), cursor_x, vecs[i].x);
        chk($sformatf("v%0d_cy", i), cursor_y, vecs[i].y);
    endtask

    initial begin
        int nb, idx, bad, guard;

        vecs[0]  = '{8'h41, 8'h07, 8'h00, 1'b1, 12'h000, 6'd1,  6'd0};
        vecs[1]  = '{8'h42, 8'h07, 8'h00, 1'b1, 12'h001, 6'd2,  6'd0};
        vecs[2]  = '{8'h0D, 8'h07, 8'h00, 1'b0, 12'h000, 6'd0,  6'd0};
        vecs[3]  = '{8'h0A, 8'h01, 8'h02, 1'b0, 12'h000, 6'd0,  6'd1};
        vecs[4]  = '{8'h43, 8'h1C, 8'h03, 1'b1, 12'h040, 6'd1,  6'd1};
        vecs[5]  = '{8'h08, 8'h07, 8'h00, 1'b0, 12'h000, 6'd0,  6'd1};
        vecs[6]  = '{8'h08, 8'h07, 8'h00, 1'b0, 12'h000, 6'd0,  6'd1};
        vecs[7]  = '{8'h44, 8'hE0, 8'h55, 1'b1, 12'h040, 6'd1,  6'd1};
        vecs[8]  = '{8'h41, 8'h07, 8'h00, 1'b1, 12'h167, 6'd0,  6'd6};
        vecs[9]  = '{8'h0D, 8'h07, 8'h00, 1'b0, 12'h000, 6'd0,  6'd6};
        vecs[10] = '{8'h08, 8'h07, 8'h00, 1'b0, 12'h000, 6'd0,  6'd6};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", chram_addr, 0);
        chk("rst_data", {chmap_data_in, fgcolram_data_in, bgcolram_data_in}, 0);
        @(negedge clk);
        ram_init = 1'b0;
        do_reset();

        // Back-to-back characters and control codes.
        for (int i = 0; i < 8; i++) apply(i);
        for (int i = 0; i < 4; i++) send(8'h0A, 8'h07, 8'h00);
        for (int i = 0; i < 39; i++) send(8'h61, 8'h07, 8'h00);
        chk("pre_cx", cursor_x, 39);
        chk("pre_cy", cursor_y, 5);
        for (int i = 8; i < 11; i++) apply(i);
        idle(1);

`ifdef CHARMAP_CONSOLE_SCROLL_EN
        // Fill the screen, then wrap past the bottom-right cell.
        do_reset();
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++)
                if (!(y == 29 && x == 39)) send(code(y, x), 8'(y), 8'(x));
        send(8'h5A, 8'h12, 8'h34);
        chk("scr_wr", chram_wr, 1);
        chk("scr_addr", chram_addr, 12'h767);
        chk("scr_ch", chmap_data_in, 8'h5A);
        chk("scr_busy", busy, 1);
        chk("scr_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        nb = 1; guard = 0;
        @(posedge clk); #1;
        while (busy && guard < 6000) begin
            nb++; guard++;
            @(posedge clk); #1;
        end
        chk("scr_busy_len", nb, 2360);
        chk("scr_lastfill_wr", chram_wr, 1);
        chk("scr_lastfill_addr", chram_addr, 12'h767);
        idle(2);
        bad = 0;
        for (int r = 0; r < 29; r++)
            for (int x = 0; x < 40; x++) begin
                if (r == 28 && x == 39) begin
                    if ({mem_ch[a(r, x)], mem_fg[a(r, x)], mem_bg[a(r, x)]} != 24'h5A1234) bad++;
                end else if (mem_ch[a(r, x)] != code(r + 1, x) || mem_fg[a(r, x)] != 8'(r + 1)
                             || mem_bg[a(r, x)] != 8'(x)) bad++;
            end
        chk("scr_copy_bad", bad, 0);
        bad = 0;
        for (int x = 0; x < 40; x++)
            if ({mem_ch[a(29, x)], mem_fg[a(29, x)], mem_bg[a(29, x)]} != 24'h201234) bad++;
        chk("scr_fill_bad", bad, 0);
        chk("scr_col40", mem_ch[a(0, 40)], 8'hEE);
        chk("scr_cx", cursor_x, 0);
        chk("scr_cy", cursor_y, 29);
`else
        // Without scroll: newline on the bottom row wraps to the top.
        for (int i = 0; i < 23; i++) send(8'h0A, 8'h07, 8'h00);
        chk("wrap_pre_cy", cursor_y, 29);
        send(8'h0A, 8'h07, 8'h00);
        chk("wrap_cx", cursor_x, 0);
        chk("wrap_cy", cursor_y, 0);
        idle(2);
        chk("wrap_no_busy", busy_total, 0);
`endif

        // Clear requested together with a character: clear wins.
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_char = 8'h41; in_fg = 8'h07; in_bg = 8'h00;
        #1;
        chk("clr_ready", in_ready, 0);
        @(posedge clk); #1;
        nb = 0; idx = 0; bad = 0; guard = 0;
        while (busy && guard < 5000) begin
            nb++; guard++;
            if (chram_wr) begin
                if (chram_addr != a(idx / 40, idx % 40) ||
                    {chmap_data_in, fgcolram_data_in, bgcolram_data_in} != 24'h20FF00) bad++;
                idx++;
            end
            @(negedge clk);
            clear = 1'b0; in_valid = 1'b0;
            @(posedge clk); #1;
        end
        chk("clr_busy_len", nb, 1200);
        chk("clr_writes", idx, 1200);
        chk("clr_bad", bad, 0);
        chk("clr_wr_after", chram_wr, 0);
        chk("clr_ready_after", in_ready, 1);
        chk("clr_cx", cursor_x, 0);
        chk("clr_cy", cursor_y, 0);
        idle(1);
        bad = 0;
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++)
                if ({mem_ch[a(y, x)], mem_fg[a(y, x)], mem_bg[a(y, x)]} != 24'h20FF00) bad++;
        chk("clr_mem_bad", bad, 0);
        chk("clr_col40", mem_ch[a(0, 40)], 8'hEE);
        chk("clr_row30", mem_ch[a(30, 0)], 8'hEE);

`ifdef CHARMAP_CONSOLE_SCROLL_EN
        // Reset in the middle of a scroll.
        for (int i = 0; i < 30; i++) send(8'h0A, 8'h07, 8'h00);
        idle(1000);
        chk("mid_busy_before", busy, 1);
`else
        // Reset in the middle of a clear.
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        idle(500);
        chk("mid_busy_before", busy, 1);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_ready", in_ready, 1);
        chk("mid_wr", chram_wr, 0);
        chk("mid_busy", busy, 0);
        chk("mid_cx", cursor_x, 0);
        chk("mid_cy", cursor_y, 0);
        @(negedge clk);
        reset = 1'b0;
        send(8'h30, 8'h07, 8'h00);
        chk("post_rst_wr", chram_wr, 1);
        chk("post_rst_addr", chram_addr, 12'h000);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
